// File: rtl/lynxTypes.sv
// lynxTypes: shared RDMA stack types and constants
package lynxTypes;
  localparam int AXI_NET_BITS = 512;
  localparam int RDMA_LEN_BITS = 28;
  localparam int DEST_BITS = 4;
  typedef struct packed {
    logic [RDMA_LEN_BITS-1:0] len;
    logic [DEST_BITS-1:0] dest;
  } req_t;
  typedef enum logic {ST_IDLE, ST_XFER} rd_resp_state_t;
endpackage

// File: rtl/axisr_skid_buffer.sv
// axisr_skid_buffer: 2-entry AXI4SR output register with a registered upstream ready
module axisr_skid_buffer #(
  parameter int DATA_BITS = 512,
  parameter int ID_BITS = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_BITS-1:0]   s_tdata,
  input  logic [DATA_BITS/8-1:0] s_tkeep,
  input  logic [ID_BITS-1:0]     s_tid,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [DATA_BITS-1:0]   m_tdata,
  output logic [DATA_BITS/8-1:0] m_tkeep,
  output logic [ID_BITS-1:0]     m_tid,
  output logic                   m_tlast
);
  localparam int W = DATA_BITS + DATA_BITS / 8 + ID_BITS + 1;
  logic [W-1:0] out_q, sk_q, in_d;
  logic out_v, sk_v, s_hs, adv;
  assign in_d = {s_tdata, s_tkeep, s_tid, s_tlast};
  assign s_tready = ~sk_v;
  assign s_hs = s_tvalid & ~sk_v;
  assign adv = m_tready | ~out_v;
  assign m_tvalid = out_v;
  assign {m_tdata, m_tkeep, m_tid, m_tlast} = out_q;
  // output slot refills from the skid slot first; the skid slot catches a beat only while output stalls
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_v <= 1'b0;
      sk_v <= 1'b0;
      out_q <= '0;
      sk_q <= '0;
    end else if (adv) begin
      out_v <= sk_v | s_hs;
      out_q <= sk_v ? sk_q : s_hs ? in_d : out_q;
      sk_v <= 1'b0;
    end else if (s_hs) begin
      sk_v <= 1'b1;
      sk_q <= in_d;
    end
  end
endmodule

// File: rtl/rdma_rd_responder.sv
// rdma_rd_responder: frames request payload from a source stream into tid/tkeep/tlast packets; RDMA_RD_RESP_STATS_EN adds request/byte counters
module rdma_rd_responder
  import lynxTypes::*;
#(
  parameter int DATA_BITS = AXI_NET_BITS,
  parameter int LEN_BITS = RDMA_LEN_BITS
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_rdma_rd_req_valid,
  output logic                   s_rdma_rd_req_ready,
  input  req_t                   s_rdma_rd_req_data,
  input  logic                   s_axis_src_tvalid,
  output logic                   s_axis_src_tready,
  input  logic [DATA_BITS-1:0]   s_axis_src_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_src_tkeep,
  input  logic                   s_axis_src_tlast,
  output logic                   m_axis_rdma_rd_tvalid,
  input  logic                   m_axis_rdma_rd_tready,
  output logic [DATA_BITS-1:0]   m_axis_rdma_rd_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_rdma_rd_tkeep,
  output logic [DEST_BITS-1:0]   m_axis_rdma_rd_tid,
  output logic                   m_axis_rdma_rd_tlast,
  output logic                   busy
`ifdef RDMA_RD_RESP_STATS_EN
  ,
  output logic [31:0]            stat_req_cnt,
  output logic [47:0]            stat_byte_cnt
`endif
);
  localparam int BEAT_BYTES = DATA_BITS / 8;
  localparam int LOG_BYTES = $clog2(BEAT_BYTES);
  localparam int BEAT_W = LEN_BITS - LOG_BYTES + 1;
  rd_resp_state_t state, state_n;
  logic [BEAT_W-1:0] cnt, cnt_n, beats;
  logic [LOG_BYTES-1:0] rem, rem_n;
  logic [DEST_BITS-1:0] dest, dest_n;
  logic [LEN_BITS-1:0] len;
  logic [BEAT_BYTES-1:0] keep;
  logic live, req_hs, src_hs, sk_ready, last, unused_src;
  assign len = s_rdma_rd_req_data.len[LEN_BITS-1:0];
  assign beats = BEAT_W'(len >> LOG_BYTES) + BEAT_W'(|len[LOG_BYTES-1:0]);
  assign s_rdma_rd_req_ready = live && state == ST_IDLE;
  assign req_hs = s_rdma_rd_req_valid && s_rdma_rd_req_ready;
  assign s_axis_src_tready = state == ST_XFER && sk_ready;
  assign src_hs = s_axis_src_tvalid && s_axis_src_tready;
  assign last = cnt == BEAT_W'(1);
  assign keep = !last || rem == '0 ? '1 : ~({BEAT_BYTES{1'b1}} << rem);
  assign busy = state == ST_XFER;
  assign unused_src = ^{s_axis_src_tkeep, s_axis_src_tlast};
  // request bookkeeping; live holds request ready low until the first clock out of reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      cnt <= '0;
      rem <= '0;
      dest <= '0;
      live <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rem <= rem_n;
      dest <= dest_n;
      live <= 1'b1;
    end
  end
  // load a request in idle (zero length is swallowed), count beats down while transferring
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rem_n = rem;
    dest_n = dest;
    if (req_hs) begin
      state_n = len == '0 ? ST_IDLE : ST_XFER;
      cnt_n = beats;
      rem_n = len[LOG_BYTES-1:0];
      dest_n = s_rdma_rd_req_data.dest;
    end
    if (src_hs) begin
      state_n = last ? ST_IDLE : ST_XFER;
      cnt_n = cnt - BEAT_W'(1);
    end
  end
`ifdef RDMA_RD_RESP_STATS_EN
  // free-running request and byte totals, wrapping at their widths
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_req_cnt <= '0;
      stat_byte_cnt <= '0;
    end else if (req_hs) begin
      stat_req_cnt <= stat_req_cnt + 32'd1;
      stat_byte_cnt <= stat_byte_cnt + 48'(len);
    end
  end
`endif
  axisr_skid_buffer #(.DATA_BITS(DATA_BITS), .ID_BITS(DEST_BITS)) u_skid (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_tvalid(s_axis_src_tvalid && state == ST_XFER),
    .s_tready(sk_ready),
    .s_tdata(s_axis_src_tdata),
    .s_tkeep(keep),
    .s_tid(dest),
    .s_tlast(last),
    .m_tvalid(m_axis_rdma_rd_tvalid),
    .m_tready(m_axis_rdma_rd_tready),
    .m_tdata(m_axis_rdma_rd_tdata),
    .m_tkeep(m_axis_rdma_rd_tkeep),
    .m_tid(m_axis_rdma_rd_tid),
    .m_tlast(m_axis_rdma_rd_tlast)
  );
endmodule
